// File: rtl/imm_field_narrower_if.sv
// Handshake bundle between the offset calculator, the narrower and the instruction-word builder.
// The master drives values in and takes results; the slave is the narrower itself.
interface imm_field_narrower_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_value;
    logic [1:0]  in_fmt;
    logic        in_scale;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_field;
    logic [1:0]  out_fmt;
    logic        out_fits;
    logic        out_misaligned;

    modport master (
        output in_valid, in_value, in_fmt, in_scale, out_ready,
        input  in_ready, out_valid, out_field, out_fmt, out_fits, out_misaligned
    );

    modport slave (
        input  in_valid, in_value, in_fmt, in_scale, out_ready,
        output in_ready, out_valid, out_field, out_fmt, out_fits, out_misaligned
    );
endinterface

// File: rtl/imm_field_narrower.sv
// Packs a 64-bit signed value into a 7/9/19/26-bit two's-complement immediate field,
// optionally dividing by 4 first. Two-stage elastic pipeline with a saturating count of
// overflowing results handed downstream.
module imm_field_narrower #(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    imm_field_narrower_if.slave bus,
    output logic [CNT_W-1:0]   ovf_count
);

    // Stage 1: raw operands
    logic        r_s1_valid;
    logic [63:0] r_s1_value;
    logic [1:0]  r_s1_fmt;
    logic        r_s1_scale;

    // Stage 2: finished result
    logic        r_s2_valid;
    logic [25:0] r_s2_field;
    logic [1:0]  r_s2_fmt;
    logic        r_s2_fits;
    logic        r_s2_mis;

    logic [CNT_W-1:0] r_ovf_count;

    logic        w_s2_load;
    logic        w_in_xfer;
    logic        w_out_xfer;
    logic [63:0] w_v;
    logic        w_fits;
    logic [25:0] w_mask;
    logic [25:0] w_smax;
    logic [25:0] w_smin;
    logic [25:0] w_field;
    logic        w_mis;

    // Handshake: s2 accepts when empty or draining; s1 accepts when empty or advancing.
    always_comb begin
        w_s2_load    = r_s1_valid & (~r_s2_valid | bus.out_ready);
        w_out_xfer   = r_s2_valid & bus.out_ready;
        bus.in_ready = ~r_s1_valid | w_s2_load;
        w_in_xfer    = bus.in_valid & bus.in_ready;
    end

    // Narrowing arithmetic on the stage-1 operands.
    always_comb begin
        w_v    = r_s1_scale ? 64'($signed(r_s1_value) >>> 2) : r_s1_value;
        w_fits = 1'b0;
        w_mask = 26'h0;
        w_smax = 26'h0;
        w_smin = 26'h0;
        unique case (r_s1_fmt)
            2'd0: begin
                w_fits = (&w_v[63:6]) | ~(|w_v[63:6]);
                w_mask = 26'h000007F;
                w_smax = 26'h000003F;
                w_smin = 26'h0000040;
            end
            2'd1: begin
                w_fits = (&w_v[63:8]) | ~(|w_v[63:8]);
                w_mask = 26'h00001FF;
                w_smax = 26'h00000FF;
                w_smin = 26'h0000100;
            end
            2'd2: begin
                w_fits = (&w_v[63:18]) | ~(|w_v[63:18]);
                w_mask = 26'h007FFFF;
                w_smax = 26'h003FFFF;
                w_smin = 26'h0040000;
            end
            default: begin
                w_fits = (&w_v[63:25]) | ~(|w_v[63:25]);
                w_mask = 26'h3FFFFFF;
                w_smax = 26'h1FFFFFF;
                w_smin = 26'h2000000;
            end
        endcase
        // Out-of-range values clamp toward the sign of v.
        w_field = w_fits ? (w_v[25:0] & w_mask) : (w_v[63] ? w_smin : w_smax);
        // Alignment is judged on the unscaled source; it never affects the field.
        w_mis   = r_s1_scale & (|r_s1_value[1:0]);
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_value <= 64'h0;
            r_s1_fmt   <= 2'd0;
            r_s1_scale <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_s1_value <= bus.in_value;
                r_s1_fmt   <= bus.in_fmt;
                r_s1_scale <= bus.in_scale;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 register; result fields hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_field <= 26'h0;
            r_s2_fmt   <= 2'd0;
            r_s2_fits  <= 1'b0;
            r_s2_mis   <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_field <= w_field;
                r_s2_fmt   <= r_s1_fmt;
                r_s2_fits  <= w_fits;
                r_s2_mis   <= w_mis;
            end else if (w_out_xfer) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // Saturating overflow counter, bumped only when an overflowing result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if (w_out_xfer && !r_s2_fits && (r_ovf_count != {CNT_W{1'b1}})) begin
            r_ovf_count <= r_ovf_count + CNT_W'(1);
        end
    end

    // Output drive.
    always_comb begin
        bus.out_valid      = r_s2_valid;
        bus.out_field      = r_s2_field;
        bus.out_fmt        = r_s2_fmt;
        bus.out_fits       = r_s2_fits;
        bus.out_misaligned = r_s2_mis;
        ovf_count          = r_ovf_count;
    end

endmodule

// File: tb/tb_imm_field_narrower.sv
// Directed bench for imm_field_narrower built with a 4-bit overflow counter.
module tb_imm_field_narrower;

    localparam int unsigned CntW = 4;

    logic            clk;
    logic            rst_n;
    logic [CntW-1:0] ovf_count;

    imm_field_narrower_if bus ();

    imm_field_narrower #(
        .CNT_W (CntW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ovf_count (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int exp_cnt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int c);
        return (c == 15) ? 15 : c + 1;
    endfunction

    // One value through an otherwise empty pipeline with out_ready held high.
    task automatic xact(input string tag, input logic [63:0] val, input logic [1:0] fmt,
                        input logic sc, input logic [25:0] ef, input logic efits,
                        input logic emis);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_value  = val;
        bus.in_fmt    = fmt;
        bus.in_scale  = sc;
        bus.out_ready = 1'b1;
        check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check_eq({tag, "_field"}, 64'(bus.out_field), 64'(ef));
        check_eq({tag, "_fits"}, 64'(bus.out_fits), 64'(efits));
        check_eq({tag, "_mis"}, 64'(bus.out_misaligned), 64'(emis));
        check_eq({tag, "_fmt"}, 64'(bus.out_fmt), 64'(fmt));
        if (!efits) exp_cnt = sat_inc(exp_cnt);
        @(negedge clk);
        check_eq({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "_cnt"}, 64'(ovf_count), 64'(exp_cnt));
    endtask

    logic [63:0] s_val   [8];
    logic [25:0] s_field [8];
    logic        s_fits  [8];

    initial begin
        int wr;
        int rd;
        int occ;
        logic stalled;
        logic [27:0] saved;
        logic in_x;
        logic out_x;

        n_vec   = 0;
        n_err   = 0;
        exp_cnt = 0;

        s_val[0] = 64'd5;                   s_field[0] = 26'h05; s_fits[0] = 1'b1;
        s_val[1] = -64'sd3;                 s_field[1] = 26'h7D; s_fits[1] = 1'b1;
        s_val[2] = 64'd64;                  s_field[2] = 26'h3F; s_fits[2] = 1'b0;
        s_val[3] = -64'sd65;                s_field[3] = 26'h40; s_fits[3] = 1'b0;
        s_val[4] = 64'd63;                  s_field[4] = 26'h3F; s_fits[4] = 1'b1;
        s_val[5] = -64'sd64;                s_field[5] = 26'h40; s_fits[5] = 1'b1;
        s_val[6] = 64'd0;                   s_field[6] = 26'h00; s_fits[6] = 1'b1;
        s_val[7] = 64'd200;                 s_field[7] = 26'h3F; s_fits[7] = 1'b0;

        bus.in_valid  = 1'b0;
        bus.in_value  = 64'h0;
        bus.in_fmt    = 2'd0;
        bus.in_scale  = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        #12;
        check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_field", 64'(bus.out_field), 64'd0);
        check_eq("rst_fits", 64'(bus.out_fits), 64'd0);
        check_eq("rst_cnt", 64'(ovf_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed single values
        xact("pos_fit7",  64'h3F, 2'd0, 1'b0, 26'h3F, 1'b1, 1'b0);
        xact("neg_fit7",  64'hFFFF_FFFF_FFFF_FFC0, 2'd0, 1'b0, 26'h40, 1'b1, 1'b0);
        xact("pos_ovf7",  64'd64, 2'd0, 1'b0, 26'h3F, 1'b0, 1'b0);
        xact("ovf19_sc",  64'h0000_0000_0400_0000, 2'd2, 1'b1, 26'h3FFFF, 1'b0, 1'b0);
        xact("neg26_sc",  -64'sd8, 2'd3, 1'b1, 26'h3FFFFFE, 1'b1, 1'b0);
        xact("mis9",      64'd6, 2'd1, 1'b1, 26'h1, 1'b1, 1'b1);
        xact("neg_ovf9",  -64'sd1000, 2'd1, 1'b0, 26'h100, 1'b0, 1'b0);
        xact("min9",      -64'sd256, 2'd1, 1'b0, 26'h100, 1'b1, 1'b0);
        xact("max9",      64'd255, 2'd1, 1'b0, 26'hFF, 1'b1, 1'b0);
        xact("neg_mis7",  -64'sd5, 2'd0, 1'b1, 26'h7E, 1'b1, 1'b1);
        xact("min64_26",  64'h8000_0000_0000_0000, 2'd3, 1'b0, 26'h2000000, 1'b0, 1'b0);
        xact("max19",     64'h3FFFF, 2'd2, 1'b0, 26'h3FFFF, 1'b1, 1'b0);
        xact("ovf19",     64'h40000, 2'd2, 1'b0, 26'h3FFFF, 1'b0, 1'b0);

        // Stream with out_ready pattern 1,0,0,1
        wr      = 0;
        rd      = 0;
        occ     = 0;
        stalled = 1'b0;
        saved   = '0;
        for (int cyc = 0; cyc < 200 && rd < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            bus.in_valid  = (wr < 8);
            bus.in_value  = (wr < 8) ? s_val[wr] : 64'h0;
            bus.in_fmt    = 2'd0;
            bus.in_scale  = 1'b0;
            #1;
            if (stalled) begin
                check_eq("stream_hold", 64'({bus.out_valid, bus.out_field, bus.out_fits}),
                         64'(saved));
            end
            check_eq("stream_in_ready", 64'(bus.in_ready),
                     64'(!(occ == 2 && !bus.out_ready)));
            in_x  = bus.in_valid & bus.in_ready;
            out_x = bus.out_valid & bus.out_ready;
            if (out_x) begin
                check_eq($sformatf("stream_field%0d", rd), 64'(bus.out_field),
                         64'(s_field[rd]));
                check_eq($sformatf("stream_fits%0d", rd), 64'(bus.out_fits), 64'(s_fits[rd]));
                if (!s_fits[rd]) exp_cnt = sat_inc(exp_cnt);
                rd++;
            end
            stalled = bus.out_valid & ~bus.out_ready;
            saved   = {1'b1, bus.out_field, bus.out_fits};
            if (in_x) wr++;
            occ = occ + int'(in_x) - int'(out_x);
        end
        check_eq("stream_count", 64'(rd), 64'd8);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("stream_cnt", 64'(ovf_count), 64'(exp_cnt));

        // Fill both stages, then reset mid-operation
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_value  = 64'd100;
        bus.in_fmt    = 2'd0;
        bus.in_scale  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("full_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("midrst_cnt", 64'(ovf_count), 64'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        xact("post_rst", 64'd10, 2'd0, 1'b0, 26'h0A, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("post_rst_single", 64'(bus.out_valid), 64'd0);

        // Counter saturation: 2^4+3 overflowing transfers
        for (int k = 0; k < 19; k++) begin
            xact($sformatf("sat%0d", k), 64'd64, 2'd0, 1'b0, 26'h3F, 1'b0, 1'b0);
        end
        check_eq("sat_final", 64'(ovf_count), 64'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_field_narrower.md
Name: imm_field_narrower

Overview:
- Inverse of the 7→64 sign extension path: takes a 64-bit signed value and packs it into a narrow two's-complement LEGv8 immediate field (7, 9, 19 or 26 bits).
- Optionally divides by 4 first, for branch offsets.
- Reports range overflow and misalignment.
- Two-stage elastic pipeline with valid/ready on both sides; sits between the assembler/loader offset calculator and the instruction-word builder.
- Keeps a saturating overflow event counter.

Parameters:
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream offers a value.
- in_ready  output  1  block accepts the value this cycle.
- in_value  input  64  signed source value.
- in_fmt  input  2  target width: 0 = 7 bits, 1 = 9 (D-format), 2 = 19 (CB-format), 3 = 26 (B-format).
- in_scale  input  1  1 = arithmetic shift right by 2 before narrowing (word offsets).
- out_valid  output  1  result available.
- out_ready  input  1  downstream takes the result.
- out_field  output  26  narrowed field, right-justified; bits above W are 0.
- out_fmt  output  2  in_fmt carried with the result.
- out_fits  output  1  1 = the value is representable in W bits.
- out_misaligned  output  1  1 = in_scale set and in_value[1:0] != 0.
- ovf_count  output  CNT_W  number of results with out_fits=0 accepted downstream; saturates.

Behaviour:
- Reset (async assert, sync release):
  - s1_valid=0, s2_valid=0, so out_valid=0.
  - out_field=0, out_fmt=0, out_fits=0, out_misaligned=0, ovf_count=0.
  - in_ready=1 from the first cycle after release.
  - Reset mid-operation discards both stages; no partial result ever appears.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Upstream holds its inputs stable while in_valid=1 and in_ready=0.
  - out_* outputs hold stable while out_valid=1 and out_ready=0.
- Pipeline:
  - Stage 1 registers in_value/in_fmt/in_scale.
  - Stage 2 registers the computed result.
  - s2 loads when s1_valid & (!s2_valid | out_ready).
  - s1 loads on an input transfer; in_ready = !s1_valid | s1 advances this cycle.
  - Latency: accept at edge N → out_valid=1 after edge N+1, i.e. 2 cycles to out_valid with out_ready held high.
  - Throughput: 1 per cycle with out_ready held high.
  - Under backpressure at most 2 results are buffered, none lost or duplicated, order preserved.
- Arithmetic, in stage 2 (combinational from s1 registers):
  - v = in_scale ? (in_value >>> 2) : in_value.
  - W comes from fmt.
  - fits = v[63:W-1] all zeros or all ones.
  - fits=1: out_field[W-1:0] = v[W-1:0].
  - fits=0: saturate to 2^(W-1)-1 if v is positive, otherwise to -2^(W-1); the result is truncated to W bits.
  - out_field[25:W] = 0 always.
  - misaligned = scale & (in_value[1:0] != 0). The field is still computed from the truncating shift; misaligned does not alter fits.
- Counter:
  - ovf_count increments by 1 on each output transfer with out_fits=0.
  - Holds at 2^CNT_W-1.
  - A stalled result is counted once only, when transferred.
- Simultaneous events:
  - Output transfer and s1→s2 advance in the same cycle are legal.
  - Input accept into a freed s1 in the same cycle is legal.

Test Plan:
- Reset, then in_value=64'h3F, fmt=0, scale=0, out_ready=1 → after 2 cycles: out_field=26'h3F, out_fits=1, out_misaligned=0.
- in_value=-64 (64'hFFFF_FFFF_FFFF_FFC0), fmt=0 → out_field=26'h40, fits=1. Then in_value=64 → out_field=26'h3F, fits=0, ovf_count=1.
- in_value=64'h0000_0000_0400_0000, fmt=2, scale=1 → v=0x0100_0000, not representable in 19 bits → out_field=19'h3FFFF, fits=0. in_value=-8, fmt=3, scale=1 → out_field=26'h3FFFFFE, fits=1.
- in_value=6, fmt=1, scale=1 → out_field=1, out_misaligned=1, out_fits=1.
- Stream of 8 values with in_valid=1 and out_ready toggled 1,0,0,1,…:
  - all 8 results arrive in order, none lost or duplicated;
  - out_* stay stable while stalled;
  - in_ready=0 only when both stages are full and out_ready=0.
- Assert rst_n low with both stages full → out_valid=0 immediately and ovf_count=0. After release, one fresh value → single result after 2 cycles.
- Force 2^CNT_W+3 overflowing transfers (CNT_W=4 in the test build) → ovf_count stays at 15.
